// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between fetch and data ports.
// Round-robin on ties, fixed-latency issue/wait/ack sequencing.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_ack_o,
  input  logic              d_req_i,
  input  logic              d_wen_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [2:0]        d_mode_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_en_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [2:0]        mem_mode_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  generate
    if (MEM_LATENCY < 1 || MEM_LATENCY > 8) begin : g_bad_lat
      $error("mem_arbiter: MEM_LATENCY must be in 1..8");
    end
  endgenerate

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  localparam logic [2:0] MODE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last_d;
  logic       gnt_d;
  logic       pick_d;

  // Data wins when alone, or on a tie when fetch went last.
  assign pick_d = d_req_i & (~i_req_i | ~last_d);

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      last_d      <= 1'b1;
      gnt_d       <= 1'b0;
      i_rdata_o   <= '0;
      i_ack_o     <= 1'b0;
      d_rdata_o   <= '0;
      d_ack_o     <= 1'b0;
      mem_en_o    <= 1'b0;
      mem_wen_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_mode_o  <= '0;
    end else begin
      i_ack_o  <= 1'b0;
      d_ack_o  <= 1'b0;
      mem_en_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req_i || d_req_i) begin
            state    <= BUSY;
            cnt      <= LAT;
            gnt_d    <= pick_d;
            last_d   <= pick_d;
            mem_en_o <= 1'b1;
            if (pick_d) begin
              mem_wen_o   <= d_wen_i;
              mem_addr_o  <= d_addr_i;
              mem_wdata_o <= d_wdata_i;
              mem_mode_o  <= d_mode_i;
            end else begin
              mem_wen_o   <= 1'b0;
              mem_addr_o  <= i_addr_i;
              mem_wdata_o <= '0;
              mem_mode_o  <= MODE_WORD;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            if (gnt_d) begin
              d_ack_o <= 1'b1;
              if (!mem_wen_o) d_rdata_o <= mem_rdata_i;
            end else begin
              i_ack_o   <= 1'b1;
              i_rdata_o <= mem_rdata_i;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Drivers queue expectations; negedge monitors pop and compare.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_wen = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_mode = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_mode;
  logic [31:0] mem_rdata = '0;

  logic        x_d_req = 1'b0;
  logic [31:0] x_d_addr = '0;
  logic [31:0] x_i_rdata;
  logic        x_i_ack;
  logic [31:0] x_d_rdata;
  logic        x_d_ack;
  logic        x_mem_en;
  logic        x_mem_wen;
  logic [31:0] x_mem_addr;
  logic [31:0] x_mem_wdata;
  logic [2:0]  x_mem_mode;
  logic [31:0] x_mem_rdata = '0;
  logic [31:0] x_p1 = '0;
  logic [31:0] x_p2 = '0;

  mem_arbiter #(.MEM_LATENCY(1)) dut (
    .clk_i(clk), .reset_i(rst),
    .i_req_i(i_req), .i_addr_i(i_addr),
    .i_rdata_o(i_rdata), .i_ack_o(i_ack),
    .d_req_i(d_req), .d_wen_i(d_wen), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_mode_i(d_mode),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack),
    .mem_en_o(mem_en), .mem_wen_o(mem_wen),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_mode_o(mem_mode), .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clk_i(clk), .reset_i(rst),
    .i_req_i(1'b0), .i_addr_i(32'h0),
    .i_rdata_o(x_i_rdata), .i_ack_o(x_i_ack),
    .d_req_i(x_d_req), .d_wen_i(1'b0), .d_addr_i(x_d_addr),
    .d_wdata_i(32'h0), .d_mode_i(3'b010),
    .d_rdata_o(x_d_rdata), .d_ack_o(x_d_ack),
    .mem_en_o(x_mem_en), .mem_wen_o(x_mem_wen),
    .mem_addr_o(x_mem_addr), .mem_wdata_o(x_mem_wdata),
    .mem_mode_o(x_mem_mode), .mem_rdata_i(x_mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: a few fixed words, otherwise addr ^ A5A50000.
  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0000_0013;
      32'h200: return 32'hDEAD_BEEF;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  logic [31:0] wmem [256];
  bit   [255:0] wv;

  // One-cycle-latency RAM model with write capture.
  always @(posedge clk) begin
    if (mem_en && mem_wen) begin
      wmem[mem_addr[9:2]] <= mem_wdata;
      wv[mem_addr[9:2]]   <= 1'b1;
    end
    if (mem_en && !mem_wen)
      mem_rdata <= wv[mem_addr[9:2]] ? wmem[mem_addr[9:2]]
                                     : memval(mem_addr);
    else
      mem_rdata <= 32'hBAD0_BAD0;
  end

  // Three-cycle-latency read-only RAM model.
  always @(posedge clk) begin
    x_p1 <= x_mem_en ? memval(x_mem_addr) : 32'hBAD0_BAD0;
    x_p2 <= x_p1;
    x_mem_rdata <= x_p2;
  end

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [2:0]  mode;
  } acc_t;

  acc_t        aq[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] xq[$];
  int          ack_cyc[$];
  bit          ack_d[$];
  int          en_cyc = 0;
  int          x_en_cyc = 0;
  bit          prev_en = 1'b0;
  logic [31:0] dlast = '0;

  // Monitor for the latency-1 instance.
  initial forever begin
    @(negedge clk);
    if (mem_en) begin
      acc_t e;
      chk("en_pulse", 64'(prev_en), 64'd0);
      if (aq.size() == 0) begin
        chk("unexp_access", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = aq.pop_front();
        chk("access", 64'({mem_addr, mem_wen, mem_mode}),
            64'({e.addr, e.wen, e.mode}));
        if (e.wen) chk("wdata", 64'(mem_wdata), 64'(e.wdata));
      end
      en_cyc = cyc;
    end
    prev_en = mem_en;
    if (i_ack || d_ack) begin
      chk("one_ack", 64'(i_ack & d_ack), 64'd0);
      chk("ack_lat", 64'(cyc), 64'(en_cyc + 2));
      ack_cyc.push_back(cyc);
      ack_d.push_back(d_ack);
    end
    if (i_ack) begin
      if (iq.size() == 0) chk("unexp_i_ack", 64'd1, 64'd0);
      else chk("i_rdata", 64'(i_rdata), 64'(iq.pop_front()));
    end
    if (d_ack) begin
      if (dq.size() == 0) chk("unexp_d_ack", 64'd1, 64'd0);
      else chk("d_rdata", 64'(d_rdata), 64'(dq.pop_front()));
    end
  end

  // Monitor for the latency-3 instance.
  initial forever begin
    @(negedge clk);
    if (x_mem_en) begin
      chk("x_access", 64'({x_mem_addr, x_mem_wen, x_mem_mode}),
          64'({32'h200, 1'b0, 3'b010}));
      x_en_cyc = cyc;
    end
    if (x_i_ack) chk("x_i_ack", 64'd1, 64'd0);
    if (x_d_ack) begin
      chk("x_lat", 64'(cyc), 64'(x_en_cyc + 4));
      if (xq.size() == 0) chk("x_unexp_ack", 64'd1, 64'd0);
      else chk("x_rdata", 64'(x_d_rdata), 64'(xq.pop_front()));
    end
  end

  task automatic fetch(input logic [31:0] a, input bit lat);
    int  t0;
    bit  got = 0;
    iq.push_back(memval(a));
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = a;
    t0     = cyc;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (i_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("i_timeout", 64'd0, 64'd1);
    else if (lat) chk("i_req2ack", 64'(cyc), 64'(t0 + 3));
  endtask

  task automatic data(input bit w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] m,
                      input bit lat);
    int  t0;
    bit  got = 0;
    if (!w) dlast = wv[a[9:2]] ? wmem[a[9:2]] : memval(a);
    dq.push_back(dlast);
    @(posedge clk);
    #1;
    d_req   = 1'b1;
    d_wen   = w;
    d_addr  = a;
    d_wdata = wd;
    d_mode  = m;
    t0      = cyc;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("d_timeout", 64'd0, 64'd1);
    else if (lat) chk("d_req2ack", 64'(cyc), 64'(t0 + 3));
  endtask

  function automatic acc_t fa(input logic [31:0] a);
    return '{addr: a, wen: 1'b0, wdata: 32'h0, mode: 3'b010};
  endfunction

  function automatic acc_t da(input logic [31:0] a, input bit w,
                              input logic [31:0] wd);
    return '{addr: a, wen: w, wdata: wd, mode: 3'b010};
  endfunction

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    dlast = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    bit seq_ok;
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'(|{i_rdata, i_ack, d_rdata, d_ack, mem_en,
        mem_wen, mem_addr, mem_wdata, mem_mode}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    aq.push_back(fa(32'h10));
    fetch(32'h10, 1);
    i_req = 1'b0;
    repeat (3) @(posedge clk);

    aq.push_back(da(32'h100, 1, 32'h539));
    data(1, 32'h100, 32'h539, 3'b010, 1);
    d_req = 1'b0;
    aq.push_back(da(32'h100, 0, 32'h0));
    data(0, 32'h100, 32'h0, 3'b010, 1);
    d_req = 1'b0;
    aq.push_back(da(32'h104, 1, 32'h77));
    data(1, 32'h104, 32'h77, 3'b010, 1);
    d_req = 1'b0;
    repeat (2) @(posedge clk);

    pulse_reset();
    ack_cyc.delete();
    ack_d.delete();
    aq.push_back(fa(32'h20));
    aq.push_back(da(32'h108, 0, 32'h0));
    aq.push_back(fa(32'h24));
    fork
      begin
        fetch(32'h20, 1);
        fetch(32'h24, 0);
        i_req = 1'b0;
      end
      begin
        data(0, 32'h108, 32'h0, 3'b010, 0);
        d_req = 1'b0;
      end
    join
    chk("tie_order", 64'({ack_d.size() == 3 ? {ack_d[0], ack_d[1],
        ack_d[2]} : 3'b111}), 64'(3'b010));
    repeat (2) @(posedge clk);

    ack_cyc.delete();
    ack_d.delete();
    for (int k = 0; k < 4; k++) begin
      aq.push_back(da(32'h110 + 32'(4 * k), 0, 32'h0));
      aq.push_back(fa(32'h30 + 32'(4 * k)));
    end
    fork
      begin
        for (int k = 0; k < 4; k++) fetch(32'h30 + 32'(4 * k), 0);
        i_req = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++)
          data(0, 32'h110 + 32'(4 * k), 32'h0, 3'b010, 0);
        d_req = 1'b0;
      end
    join
    chk("rr_count", 64'(ack_cyc.size()), 64'd8);
    seq_ok = (ack_cyc.size() == 8);
    for (int k = 0; k < 8 && k < ack_cyc.size(); k++) begin
      if (ack_d[k] != ((k % 2) == 0)) seq_ok = 0;
      if (k > 0 && ack_cyc[k] - ack_cyc[k-1] != 4) seq_ok = 0;
    end
    chk("rr_alt_gap4", 64'(seq_ok), 64'd1);
    repeat (2) @(posedge clk);

    xq.push_back(32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    x_d_req  = 1'b1;
    x_d_addr = 32'h200;
    t0       = cyc;
    seq_ok   = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (x_d_ack) begin
        seq_ok = 1;
        break;
      end
    end
    if (!seq_ok) chk("x_timeout", 64'd0, 64'd1);
    else chk("x_req2ack", 64'(cyc), 64'(t0 + 5));
    x_d_req = 1'b0;
    repeat (2) @(posedge clk);

    ack_cyc.delete();
    aq.push_back(fa(32'h40));
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    dlast = '0;
    #1;
    chk("rst_mid_outs", 64'(|{i_rdata, i_ack, d_rdata, d_ack, mem_en,
        mem_wen, mem_addr, mem_wdata, mem_mode}), 64'd0);
    i_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    chk("no_ack_abandoned", 64'(ack_cyc.size()), 64'd0);
    aq.push_back(fa(32'h44));
    fetch(32'h44, 1);
    i_req = 1'b0;
    repeat (3) @(posedge clk);

    chk("queues_empty", 64'(aq.size() + iq.size() + dq.size()
        + xq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
